// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Multi-cycle DATA_W-bit signed/unsigned integer divider for the execute
//   stage (DIV/DIVU). Restoring shift-subtract, one quotient bit per cycle.
//   The execute stage holds start_i high until it has consumed ready_o; the
//   result {remainder, quotient} then feeds the HI/LO write path.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active low
//   signed_div_i in   1 = DIV (two's complement), 0 = DIVU
//   opdata1_i    in   dividend, sampled only when a start is accepted
//   opdata2_i    in   divisor, sampled only when a start is accepted
//   start_i      in   request, held high until the result is consumed
//   annul_i      in   abort an in-flight division (branch/flush)
//   result_o     out  {remainder, quotient}, registered
//   ready_o      out  result_o valid, registered
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    localparam int              CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [DATA_W-1:0]  rem_q, rem_d;   // partial remainder
    logic [DATA_W-1:0]  quo_q, quo_d;   // dividend shifting out, quotient shifting in
    logic [DATA_W-1:0]  dvs_q, dvs_d;   // |divisor|
    logic               neg_quo, neg_quo_d;
    logic               neg_rem, neg_rem_d;
    logic [2*DATA_W-1:0] result_d;
    logic               ready_d;

    // Operand magnitudes; the most negative value maps onto itself, which is
    // the correct unsigned magnitude.
    logic [DATA_W-1:0]  op1_abs, op2_abs;
    assign op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    // One restoring step. rem_q < dvs_q, so the shifted value is below
    // 2*dvs_q and the difference fits in DATA_W+1 bits; its MSB is the borrow.
    logic [DATA_W:0]    shifted, diff;
    assign shifted = {rem_q, quo_q[DATA_W-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    logic [DATA_W-1:0]  quo_fix, rem_fix;
    assign quo_fix = neg_quo ? -quo_q : quo_q;
    assign rem_fix = neg_rem ? -rem_q : rem_q;

    logic abort;
    assign abort = annul_i || !start_i;

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo;
        neg_rem_d = neg_rem;
        result_d  = result_o;
        ready_d   = ready_o;

        unique case (state)
            S_IDLE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    cnt_d = '0;
                    rem_d = '0;
                    if (opdata2_i == '0) begin
                        state_d   = S_BYZERO;
                        quo_d     = '0;
                        dvs_d     = '0;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                    end else begin
                        state_d   = S_ON;
                        quo_d     = op1_abs;
                        dvs_d     = op2_abs;
                        neg_quo_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        neg_rem_d = signed_div_i & opdata1_i[DATA_W-1];
                    end
                end
            end

            // Divide-by-zero answers 0 after two cycles; cnt paces it.
            S_BYZERO: begin
                if (abort) begin
                    state_d = S_IDLE;
                    ready_d = 1'b0;
                end else if (cnt == ONE) begin
                    state_d  = S_END;
                    result_d = '0;
                    ready_d  = 1'b1;
                end else begin
                    cnt_d = cnt + ONE;
                end
            end

            // cnt 0..DATA_W-1 are iterations; the cnt==DATA_W cycle publishes.
            S_ON: begin
                if (abort) begin
                    state_d = S_IDLE;
                    ready_d = 1'b0;
                end else if (cnt == LAST) begin
                    state_d  = S_END;
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                end else begin
                    cnt_d = cnt + ONE;
                    if (!diff[DATA_W]) begin
                        rem_d = diff[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b0};
                    end
                end
            end

            // Result already complete: annul_i is ignored, only start_i drop ends it.
            S_END: begin
                if (!start_i) begin
                    state_d  = S_IDLE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            neg_quo  <= neg_quo_d;
            neg_rem  <= neg_rem_d;
            result_o <= result_d;
            ready_o  <= ready_d;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int cmp_n = 0;
    int err_n = 0;

    logic [63:0] exp_res_q[$];
    int          exp_lat_q[$];

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    // Reference: language division truncates toward zero and the remainder
    // takes the dividend's sign; the wrap case and /0 are explicit.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000; r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic push_exp(input logic [63:0] res, input int lat);
        exp_res_q.push_back(res);
        exp_lat_q.push_back(lat);
    endtask

    // Drives one request, scrambles operands after acceptance, waits for
    // ready_o, checks one extra held cycle, then drops start_i.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] res, output logic [63:0] res_hold, output int lat);
        signed_div_i = s; opdata1_i = a; opdata2_i = b; annul_i = 1'b0; start_i = 1'b1;
        @(posedge clk); #1;
        opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~s;
        lat = -1; res = '0; res_hold = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ready_o) begin
                lat = i; res = result_o; break;
            end
        end
        if (lat > 0) begin
            annul_i = 1'b1;   // ignored once the result is complete
            @(posedge clk); #1;
            res_hold = ready_o ? result_o : ~res;
            annul_i = 1'b0;
        end
        start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        cmp_n++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            err_n++; $display("FAIL reset: ready=%b result=%h required ready=0 result=0", ready_o, result_o);
        end
        #3 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmp_n++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            err_n++; $display("FAIL post_reset_idle: ready=%b result=%h required 0/0", ready_o, result_o);
        end
    endtask

    // Shared body for table-driven tasks: compare popped expectations inline.
    task automatic test_spec_cases();
        logic [63:0] res, hold, e_res;
        int lat, e_lat;
        logic        s_t[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] a_t[5]  = '{32'd100, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] b_t[5]  = '{32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd1};
        logic [63:0] r_t[5]  = '{64'h00000002_0000000E, 64'hFFFFFFFF_FFFFFFFD, 64'd0,
                                 64'h00000000_80000000, 64'h00000000_FFFFFFFF};
        int          l_t[5]  = '{33, 33, 2, 33, 33};
        for (int k = 0; k < 5; k++) begin
            push_exp(r_t[k], l_t[k]);
            run_div(s_t[k], a_t[k], b_t[k], res, hold, lat);
            e_res = exp_res_q.pop_front();
            e_lat = exp_lat_q.pop_front();
            cmp_n++;
            if (lat !== e_lat) begin
                err_n++; $display("FAIL spec%0d_latency: got %0d required %0d", k, lat, e_lat);
            end
            cmp_n++;
            if (res !== e_res) begin
                err_n++; $display("FAIL spec%0d_result: got %h required %h", k, res, e_res);
            end
            cmp_n++;
            if (hold !== e_res) begin
                err_n++; $display("FAIL spec%0d_hold: got %h required %h", k, hold, e_res);
            end
            cmp_n++;
            if (ready_o !== 1'b0 || result_o !== 64'd0) begin
                err_n++; $display("FAIL spec%0d_release: ready=%b result=%h required 0/0", k, ready_o, result_o);
            end
        end
    endtask

    task automatic test_annul();
        logic [63:0] res, hold, e_res;
        int lat, e_lat;
        logic seen;
        // annul at N+10; start stays high with annul high, which must not restart
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1; annul_i = 1'b0;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1 annul_i = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready_o) seen = 1'b1;
        end
        cmp_n++;
        if (seen !== 1'b0) begin
            err_n++; $display("FAIL annul_no_ready: ready seen=%b required 0", seen);
        end
        start_i = 1'b0; annul_i = 1'b0;
        @(posedge clk); #1;
        // dropping start_i mid-ON also aborts
        opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1 start_i = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready_o) seen = 1'b1;
        end
        cmp_n++;
        if (seen !== 1'b0) begin
            err_n++; $display("FAIL start_drop_abort: ready seen=%b required 0", seen);
        end
        push_exp(64'h00000000_00000003, 33);
        run_div(1'b0, 32'd9, 32'd3, res, hold, lat);
        e_res = exp_res_q.pop_front();
        e_lat = exp_lat_q.pop_front();
        cmp_n++;
        if (lat !== e_lat || res !== e_res) begin
            err_n++; $display("FAIL after_annul: got lat=%0d res=%h required lat=%0d res=%h", lat, res, e_lat, e_res);
        end
    endtask

    task automatic test_async_reset();
        logic seen;
        logic [63:0] res, hold;
        int lat;
        // reset mid-ON at N+20
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1; annul_i = 1'b0;
        @(posedge clk); #1;
        repeat (19) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        cmp_n++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            err_n++; $display("FAIL reset_mid_on: ready=%b result=%h required 0/0", ready_o, result_o);
        end
        start_i = 1'b0;
        @(posedge clk); #3 rst = 1'b1;
        // reset while a result is being held must clear it without an edge
        signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1;
        @(posedge clk); #1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ready_o) begin lat = i; break; end
        end
        cmp_n++;
        if (lat !== 33 || result_o !== 64'h00000000_0000000A) begin
            err_n++; $display("FAIL pre_reset_result: got lat=%0d res=%h required lat=33 res=%h", lat, result_o, 64'h0000000A);
        end
        #2 rst = 1'b0;
        #1;
        cmp_n++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            err_n++; $display("FAIL reset_in_end: ready=%b result=%h required 0/0", ready_o, result_o);
        end
        start_i = 1'b0;
        @(posedge clk); #3 rst = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready_o || result_o !== 64'd0) seen = 1'b1;
        end
        cmp_n++;
        if (seen !== 1'b0) begin
            err_n++; $display("FAIL stale_after_reset: activity=%b required 0", seen);
        end
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, res, hold, lat);
        cmp_n++;
        if (res !== 64'hFFFFFFFE_FFFFFFF2 || lat !== 33) begin
            err_n++; $display("FAIL after_reset_div: got lat=%0d res=%h required lat=33 res=%h", lat, res, 64'hFFFFFFFE_FFFFFFF2);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] res, hold, e_res;
        int lat, e_lat;
        logic s;
        logic [31:0] a, b;
        for (int k = 0; k < 20; k++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case (k % 5)
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: b = -32'($urandom_range(1, 1000));
                default: b = $urandom;
            endcase
            if (b == 32'd0 && (k % 5) != 0) b = 32'd1;
            push_exp(ref_div(s, a, b), (b == 32'd0) ? 2 : 33);
            run_div(s, a, b, res, hold, lat);
            e_res = exp_res_q.pop_front();
            e_lat = exp_lat_q.pop_front();
            cmp_n++;
            if (lat !== e_lat || res !== e_res || hold !== e_res) begin
                err_n++;
                $display("FAIL b2b%0d s=%b a=%h b=%h: got lat=%0d res=%h hold=%h required lat=%0d res=%h",
                         k, s, a, b, lat, res, hold, e_lat, e_res);
            end
        end
    endtask

    initial begin
        test_reset();
        test_spec_cases();
        test_annul();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
